// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave power controller.
// State codes are fixed because estado is exported for display/debug.
package microondas_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    LIGADO    = 3'd1,
    DESLIGADO = 3'd2,
    PAUSA     = 3'd3,
    BIP       = 3'd4
  } estado_pot_t;

  localparam logic [3:0] NIVEL_MAX = 4'd10;

  localparam int CICLO_JANELA_PADRAO   = 1000;
  localparam int PASSO_PADRAO          = 100;
  localparam int BIP_CICLOS_PADRAO     = 50;
  localparam int BIP_REPETICOES_PADRAO = 3;

  // Out-of-range requests (0 or above the maximum) cook at full power.
  function automatic logic [3:0] satura_nivel(input logic [3:0] nivel);
    if ((nivel == 4'd0) || (nivel > NIVEL_MAX)) begin
      satura_nivel = NIVEL_MAX;
    end else begin
      satura_nivel = nivel;
    end
  endfunction

endpackage

// File: rtl/gerador_bip.sv
// End-of-cook beep pattern: BIP_REPETICOES x (BIP_CICLOS on, BIP_CICLOS off).
// fim is high during the final cycle of the last off interval.
module gerador_bip
  import microondas_pkg::*;
#(
  parameter int BIP_CICLOS     = BIP_CICLOS_PADRAO,
  parameter int BIP_REPETICOES = BIP_REPETICOES_PADRAO
) (
  input  logic clk100Hz,
  input  logic clrn,
  input  logic inicio,
  output logic bip,
  output logic fim
);

  localparam int CW = $clog2(BIP_CICLOS + 1);
  localparam int RW = $clog2(BIP_REPETICOES + 1);
  localparam logic [CW-1:0] CNT_ULT = CW'(BIP_CICLOS - 1);
  localparam logic [RW-1:0] REP_ULT = RW'(BIP_REPETICOES - 1);

  logic          r_ativo;
  logic          r_bip;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_rep;
  logic          w_fim_intervalo;

  assign w_fim_intervalo = (r_cnt == CNT_ULT);

  // Interval and repetition counters; inicio restarts the pattern with bip high.
  always_ff @(posedge clk100Hz or negedge clrn) begin
    if (!clrn) begin
      r_ativo <= 1'b0;
      r_bip   <= 1'b0;
      r_cnt   <= '0;
      r_rep   <= '0;
    end else if (inicio) begin
      r_ativo <= 1'b1;
      r_bip   <= 1'b1;
      r_cnt   <= '0;
      r_rep   <= '0;
    end else if (r_ativo) begin
      if (w_fim_intervalo) begin
        r_cnt <= '0;
        if (r_bip) begin
          r_bip <= 1'b0;
        end else if (r_rep == REP_ULT) begin
          r_ativo <= 1'b0;
        end else begin
          r_rep <= r_rep + RW'(1);
          r_bip <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bip = r_bip;
  assign fim = r_ativo & ~r_bip & w_fim_intervalo & (r_rep == REP_ULT);

endmodule

// File: rtl/controle_potencia.sv
// Power-level duty-cycle controller with pause/resume and end-of-cook beep.
// mag_on is gated combinationally by the door so opening it cuts power at once.
module controle_potencia
  import microondas_pkg::*;
#(
  parameter int CICLO_JANELA   = CICLO_JANELA_PADRAO,
  parameter int PASSO          = PASSO_PADRAO,
  parameter int BIP_CICLOS     = BIP_CICLOS_PADRAO,
  parameter int BIP_REPETICOES = BIP_REPETICOES_PADRAO
) (
  input  logic       clk100Hz,
  input  logic       clrn,
  input  logic       ligar,
  input  logic       zero,
  input  logic       porta_fechada,
  input  logic [3:0] nivel,
  output logic       mag_on,
  output logic       bip,
  output logic [3:0] nivel_ativo,
  output logic [2:0] estado
);

  localparam int CNT_W = $clog2(CICLO_JANELA);
  localparam int LIM_W = 4 + $clog2(PASSO);
  localparam int CMP_W = (CNT_W > LIM_W) ? CNT_W : LIM_W;
  localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(CICLO_JANELA - 1);

  estado_pot_t      r_estado;
  estado_pot_t      w_estado_prox;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_prox;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       r_nivel_ativo;
  logic [3:0]       w_nivel_prox;
  logic             r_mag;
  logic             w_mag_prox;
  logic             w_inicio;
  logic             w_fim;
  logic [LIM_W-1:0] w_lim;
  logic             w_abaixo_inc;
  logic             w_abaixo_cnt;

  assign w_lim        = LIM_W'(r_nivel_ativo) * LIM_W'(PASSO);
  assign w_cnt_inc    = (r_cnt == CNT_ULT) ? '0 : r_cnt + CNT_W'(1);
  assign w_abaixo_inc = CMP_W'(w_cnt_inc) < CMP_W'(w_lim);
  assign w_abaixo_cnt = CMP_W'(r_cnt) < CMP_W'(w_lim);

  // State, duty counter, latched level and registered magnetron request.
  always_ff @(posedge clk100Hz or negedge clrn) begin
    if (!clrn) begin
      r_estado      <= OCIOSO;
      r_cnt         <= '0;
      r_nivel_ativo <= 4'd0;
      r_mag         <= 1'b0;
    end else begin
      r_estado      <= w_estado_prox;
      r_cnt         <= w_cnt_prox;
      r_nivel_ativo <= w_nivel_prox;
      r_mag         <= w_mag_prox;
    end
  end

  // Next state; cnt only advances while cooking, so a pause holds the window position.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_nivel_prox  = r_nivel_ativo;
    case (r_estado)
      OCIOSO: begin
        if (ligar) begin
          w_nivel_prox  = satura_nivel(nivel);
          w_cnt_prox    = '0;
          w_estado_prox = LIGADO;
        end else begin
          w_estado_prox = OCIOSO;
        end
      end
      LIGADO, DESLIGADO: begin
        if (zero) begin
          w_estado_prox = BIP;
        end else if (!ligar || !porta_fechada) begin
          w_estado_prox = PAUSA;
        end else begin
          w_cnt_prox    = w_cnt_inc;
          w_estado_prox = w_abaixo_inc ? LIGADO : DESLIGADO;
        end
      end
      PAUSA: begin
        if (zero) begin
          w_estado_prox = BIP;
        end else if (ligar && porta_fechada) begin
          w_estado_prox = w_abaixo_cnt ? LIGADO : DESLIGADO;
        end else begin
          w_estado_prox = PAUSA;
        end
      end
      BIP: begin
        if (w_fim) begin
          w_estado_prox = OCIOSO;
        end else begin
          w_estado_prox = BIP;
        end
      end
      default: begin
        w_estado_prox = OCIOSO;
      end
    endcase
  end

  // Registered-output requests derived from the next state.
  always_comb begin
    w_mag_prox = (w_estado_prox == LIGADO);
    w_inicio   = (w_estado_prox == BIP) && (r_estado != BIP);
  end

  gerador_bip #(
    .BIP_CICLOS     (BIP_CICLOS),
    .BIP_REPETICOES (BIP_REPETICOES)
  ) u_gerador_bip (
    .clk100Hz (clk100Hz),
    .clrn     (clrn),
    .inicio   (w_inicio),
    .bip      (bip),
    .fim      (w_fim)
  );

  assign mag_on      = r_mag & porta_fechada;
  assign nivel_ativo = r_nivel_ativo;
  assign estado      = r_estado;

endmodule
